detector_colisao: RTL
=====================

// Module: detector_colisao
// PURPOSE
//  Consumer side of the opponent-position interface: once per frame, snapshots the player car
//  and the three opponent positions, tests player/opponent bounding-box overlap sequentially,
//  and maintains lives, invulnerability and game-over state.
//  Sits between controle_oponentes and the VGA renderer / game-state logic.
// PARAMETERS
//  CARRO_L        20   car bounding-box width, pixels (same for player and opponents)
//  CARRO_A        40   car bounding-box height, pixels
//  VIDAS_INICIAIS 3    lives loaded at reset (1..7)
//  INVULN_QUADROS 60   frames of collision immunity after a registered hit (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  quadro_tick  in   1   one-cycle pulse at frame start; starts one check pass
//  jogador_x    in   10  player car left edge
//  jogador_y    in   9   player car top edge
//  oponente1_x  in   10  opponent 1 left edge; oponente1_y in 9 top edge
//  oponente2_x  in   10  opponent 2 left edge; oponente2_y in 9 top edge
//  oponente3_x  in   10  opponent 3 left edge; oponente3_y in 9 top edge
//  ocupado      out  1   high while a check pass is in progress
//  colisao      out  1   one-cycle pulse when a hit is registered
//  oponente_hit out  2   index (1..3) of the lowest-numbered hit opponent; 0 = none
//  vidas        out  3   remaining lives
//  invulneravel out  1   high while the immunity counter is non-zero
//  game_over    out  1   sticky; set when vidas reaches 0
//  pontos       out  16  frames survived (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): FSM=OCIOSO, ocupado=0, colisao=0, oponente_hit=0, vidas=VIDAS_INICIAIS,
//   invulneravel=0, immunity counter=0, game_over=0, pontos=0. Mid-pass reset aborts the pass.
//  FSM: OCIOSO -> CAPTURA -> TESTA(i=1,2,3; one cycle each) -> RESOLVE -> OCIOSO.
//   OCIOSO: on quadro_tick && !game_over -> CAPTURA. quadro_tick outside OCIOSO is ignored.
//   CAPTURA: registers all 8 position inputs; ocupado=1 from this cycle through RESOLVE.
//   TESTA: overlap_i = |px-ox| < CARRO_L && |py-oy| < CARRO_A. Differences computed as
//    11-bit signed (x) / 10-bit signed (y) after zero-extension; no wrap. Opponent y may be
//    480..486 (off-screen) and is compared as-is. Hits are OR-accumulated; the first hit index is kept.
//   RESOLVE: if any hit && counter==0: colisao=1 for this cycle, oponente_hit=index,
//    vidas-=1 (saturating at 0), counter=INVULN_QUADROS. If vidas becomes 0, game_over=1.
//    If a hit occurs while counter!=0: no pulse, oponente_hit=0, vidas unchanged.
//    If counter!=0 (and no new load), counter decrements once per pass.
//  Latency: colisao is high exactly 5 cycles after the cycle quadro_tick is sampled.
//  oponente_hit holds its value until the next RESOLVE.
//  invulneravel = (counter != 0), registered. game_over blocks further passes until reset.
// CONFIGURATION
//  COLISAO_PONTOS_EN defined: pontos increments (saturating at 16'hFFFF) in every RESOLVE
//   with no registered hit while !game_over; freezes when game_over is set.
//  Not defined: pontos is tied to 16'd0; no counter logic is generated.
// STRUCTURE
//  Shared package/include (jogo_defs): CARRO_L, CARRO_A, ALTURA_TELA=480, lane x constants
//   (178, 284, 391), FSM state encodings, X_W=10, Y_W=9.
//  Sub-module sobreposicao_caixa: combinational single-pair AABB test; instantiated once,
//   with the current opponent selected by a mux on i.
// TESTING
//  1 Player(178,150), op1(178,150), others far; tick -> colisao pulse at +5, hit=1, vidas 3->2, invulneravel=1.
//  2 Same overlap held on the next 59 ticks -> no pulse, vidas=2; tick 61 -> pulse, vidas=1.
//  3 |dx|=CARRO_L exactly (player x=198, op x=178, same y) -> no hit; x=197 -> hit.
//  4 Op2 and op3 both overlapping -> hit=2, single life lost; then vidas 1->0 -> game_over=1, further ticks ignored.
//  5 Assert reset during TESTA -> all outputs at reset values next cycle, ocupado=0.
//  6 COLISAO_PONTOS_EN: 10 clean ticks -> pontos=10; undefined -> pontos=0 throughout.

Source files
------------

// File: rtl/detector_colisao_pkg.sv
// Shared game definitions for the collision detector: screen/lane geometry, field widths, FSM states.
package detector_colisao_pkg;

    localparam int X_W            = 10;
    localparam int Y_W            = 9;
    localparam int CARRO_L_PADRAO = 20;
    localparam int CARRO_A_PADRAO = 40;
    localparam int ALTURA_TELA    = 480;
    localparam int FAIXA_ESQ      = 178;
    localparam int FAIXA_MEIO     = 284;
    localparam int FAIXA_DIR      = 391;

    typedef enum logic [1:0] {
        OCIOSO,
        CAPTURA,
        TESTA,
        RESOLVE
    } estado_t;

endpackage

// File: rtl/detector_colisao_sobreposicao_caixa.sv
// Combinational AABB overlap test for one player/opponent pair of equal-size boxes.
module sobreposicao_caixa
    import detector_colisao_pkg::*;
#(
    parameter int CARRO_L = CARRO_L_PADRAO,
    parameter int CARRO_A = CARRO_A_PADRAO
) (
    input  logic [X_W-1:0] px,
    input  logic [Y_W-1:0] py,
    input  logic [X_W-1:0] ox,
    input  logic [Y_W-1:0] oy,
    output logic           sobrepoe
);

    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic        [X_W:0] adx;
    logic        [Y_W:0] ady;

    // One extra sign bit keeps the difference exact: no wrap at screen edges.
    always_comb begin
        dx       = $signed({1'b0, px}) - $signed({1'b0, ox});
        dy       = $signed({1'b0, py}) - $signed({1'b0, oy});
        adx      = dx[X_W] ? $unsigned(-dx) : $unsigned(dx);
        ady      = dy[Y_W] ? $unsigned(-dy) : $unsigned(dy);
        sobrepoe = (adx < (X_W+1)'(CARRO_L)) && (ady < (Y_W+1)'(CARRO_A));
    end

endmodule

// File: rtl/detector_colisao.sv
// Per-frame player/opponent collision checker with lives, immunity and game-over state.
// Optional frame-survival score enabled by defining COLISAO_PONTOS_EN.
module detector_colisao
    import detector_colisao_pkg::*;
#(
    parameter int CARRO_L        = CARRO_L_PADRAO,
    parameter int CARRO_A        = CARRO_A_PADRAO,
    parameter int VIDAS_INICIAIS = 3,
    parameter int INVULN_QUADROS = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           quadro_tick,
    input  logic [X_W-1:0] jogador_x,
    input  logic [Y_W-1:0] jogador_y,
    input  logic [X_W-1:0] oponente1_x,
    input  logic [Y_W-1:0] oponente1_y,
    input  logic [X_W-1:0] oponente2_x,
    input  logic [Y_W-1:0] oponente2_y,
    input  logic [X_W-1:0] oponente3_x,
    input  logic [Y_W-1:0] oponente3_y,
    output logic           ocupado,
    output logic           colisao,
    output logic [1:0]     oponente_hit,
    output logic [2:0]     vidas,
    output logic           invulneravel,
    output logic           game_over,
    output logic [15:0]    pontos
);

    estado_t        estado, estado_d;
    logic [X_W-1:0] cap_x [4];
    logic [Y_W-1:0] cap_y [4];
    logic [1:0]     i;
    logic           hit_acc;
    logic [1:0]     idx_acc;
    logic [7:0]     cnt, cnt_d;
    logic           ov, hit_fim, fim, registra;
    logic [1:0]     idx_fim;

    sobreposicao_caixa #(
        .CARRO_L(CARRO_L),
        .CARRO_A(CARRO_A)
    ) u_caixa (
        .px      (cap_x[0]),
        .py      (cap_y[0]),
        .ox      (cap_x[i]),
        .oy      (cap_y[i]),
        .sobrepoe(ov)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_d;
    end

    // Immunity counts down at capture so the hit frame itself is one of the immune frames.
    always_comb begin
        estado_d = estado;
        case (estado)
            OCIOSO:  if (quadro_tick && !game_over) estado_d = CAPTURA;
            CAPTURA: estado_d = TESTA;
            TESTA:   if (i == 2'd3) estado_d = RESOLVE;
            RESOLVE: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        ocupado  = (estado != OCIOSO);
        hit_fim  = hit_acc | ov;
        idx_fim  = hit_acc ? idx_acc : (ov ? i : 2'd0);
        fim      = (estado == TESTA) && (i == 2'd3);
        registra = fim && hit_fim && (cnt == '0);
        cnt_d    = cnt;
        if (estado == CAPTURA && cnt != '0) cnt_d = cnt - 8'd1;
        if (registra) cnt_d = 8'(INVULN_QUADROS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < 4; k++) begin
                cap_x[k] <= '0;
                cap_y[k] <= '0;
            end
            i            <= '0;
            hit_acc      <= 1'b0;
            idx_acc      <= '0;
            cnt          <= '0;
            invulneravel <= 1'b0;
            colisao      <= 1'b0;
            oponente_hit <= '0;
            vidas        <= 3'(VIDAS_INICIAIS);
            game_over    <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            invulneravel <= (cnt_d != '0);
            colisao      <= registra;
            if (estado == CAPTURA) begin
                cap_x[0] <= jogador_x;   cap_y[0] <= jogador_y;
                cap_x[1] <= oponente1_x; cap_y[1] <= oponente1_y;
                cap_x[2] <= oponente2_x; cap_y[2] <= oponente2_y;
                cap_x[3] <= oponente3_x; cap_y[3] <= oponente3_y;
                i       <= 2'd1;
                hit_acc <= 1'b0;
                idx_acc <= '0;
            end else if (estado == TESTA) begin
                i       <= i + 2'd1;
                hit_acc <= hit_fim;
                idx_acc <= idx_fim;
            end
            if (fim) begin
                oponente_hit <= registra ? idx_fim : 2'd0;
                if (registra) begin
                    vidas <= (vidas != '0) ? vidas - 3'd1 : 3'd0;
                    if (vidas <= 3'd1) game_over <= 1'b1;
                end
            end
        end
    end

`ifdef COLISAO_PONTOS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pontos <= '0;
        else if (fim && !registra && !game_over && pontos != '1)
            pontos <= pontos + 16'd1;
    end
`else
    always_comb pontos = '0;
`endif

endmodule
